// File: rtl/cas4_sort.sv
// Four-input unsigned sorting network (3-stage Batcher, 5 CAS elements) with
// one registered output bank; outputs are presented in descending order.
module cas4_sort #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] a_new,
    output logic [WIDTH-1:0] b_new,
    output logic [WIDTH-1:0] c_new,
    output logic [WIDTH-1:0] d_new,
    output logic             valid
);

    // Returns {hi, lo}; on a tie hi takes x.
    function automatic logic [2*WIDTH-1:0] cas(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y);
        return (x >= y) ? {x, y} : {y, x};
    endfunction

    logic [WIDTH-1:0] h1_p0, l1_p0, h2_p0, l2_p0;
    logic [WIDTH-1:0] max_p0, m1_p0, m2_p0, min_p0;
    logic [WIDTH-1:0] second_p0, third_p0;

    logic [WIDTH-1:0] max_p1, second_p1, third_p1, min_p1;
    logic             vld_p1;

    // Stage p0: combinational network, S1 -> S2 -> S3
    always_comb begin
        {h1_p0, l1_p0}         = cas(a, b);
        {h2_p0, l2_p0}         = cas(c, d);
        {max_p0, m1_p0}        = cas(h1_p0, h2_p0);
        {m2_p0, min_p0}        = cas(l1_p0, l2_p0);
        {second_p0, third_p0}  = cas(m1_p0, m2_p0);
    end

    // Stage p1: output register bank
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_p1    <= '0;
            second_p1 <= '0;
            third_p1  <= '0;
            min_p1    <= '0;
            vld_p1    <= 1'b0;
        end else begin
            vld_p1 <= en;
            if (en) begin
                max_p1    <= max_p0;
                second_p1 <= second_p0;
                third_p1  <= third_p0;
                min_p1    <= min_p0;
            end
        end
    end

    assign a_new = max_p1;
    assign b_new = second_p1;
    assign c_new = third_p1;
    assign d_new = min_p1;
    assign valid = vld_p1;

endmodule

// File: tb/tb_cas4_sort.sv
// Self-checking bench for cas4_sort: vector table, hand sequences for reset,
// enable hold and back-to-back traffic, plus a random regression.
module tb_cas4_sort;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0, c = '0, d = '0;
    logic [WIDTH-1:0] a_new, b_new, c_new, d_new;
    logic             valid;

    cas4_sort #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .en(en),
        .a(a), .b(b), .c(c), .d(d),
        .a_new(a_new), .b_new(b_new), .c_new(c_new), .d_new(d_new),
        .valid(valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b, c, d;
        logic [7:0] ea, eb, ec, ed;
    } vec_t;

    int checks = 0;
    int errors = 0;
    logic [31:0] q[$];
    logic [31:0] last_exp = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: bubble sort, descending, packed {max,2nd,3rd,min}.
    function automatic logic [31:0] sort4(input logic [7:0] x0, x1, x2, x3);
        logic [7:0] v[4];
        logic [7:0] t;
        v[0] = x0; v[1] = x1; v[2] = x2; v[3] = x3;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3 - i; j++)
                if (v[j] < v[j+1]) begin
                    t = v[j]; v[j] = v[j+1]; v[j+1] = t;
                end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic check_outputs(input logic [31:0] exp, input logic exp_valid);
        chk("valid", {31'd0, valid}, {31'd0, exp_valid});
        chk("a_new", {24'd0, a_new}, {24'd0, exp[31:24]});
        chk("b_new", {24'd0, b_new}, {24'd0, exp[23:16]});
        chk("c_new", {24'd0, c_new}, {24'd0, exp[15:8]});
        chk("d_new", {24'd0, d_new}, {24'd0, exp[7:0]});
        chk("descending", {31'd0, (a_new >= b_new) && (b_new >= c_new) && (c_new >= d_new)}, 32'd1);
    endtask

    // Called at a negedge: drive inputs, push expectation, clock once, check.
    task automatic apply(input logic e, input logic [7:0] x0, x1, x2, x3, input logic [31:0] expw);
        logic [31:0] exp;
        en = e; a = x0; b = x1; c = x2; d = x3;
        if (e) q.push_back(expw);
        @(posedge clk);
        @(negedge clk);
        if (e) begin
            chk("queue_depth", q.size(), 32'd1);
            exp = (q.size() > 0) ? q.pop_front() : 32'hxxxx_xxxx;
            last_exp = exp;
            check_outputs(exp, 1'b1);
        end else begin
            check_outputs(last_exp, 1'b0);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_valid"}, {31'd0, valid}, 32'd0);
        chk({tag, "_outs"}, {a_new, b_new, c_new, d_new}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[6];
        logic [7:0] r0, r1, r2, r3;
        vecs[0] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd40, 8'd30, 8'd20, 8'd10};
        vecs[1] = '{8'd40, 8'd30, 8'd20, 8'd10, 8'd40, 8'd30, 8'd20, 8'd10};
        vecs[2] = '{8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd255, 8'd0, 8'd0};
        vecs[3] = '{8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7, 8'd7};
        vecs[4] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        vecs[5] = '{8'd3, 8'd200, 8'd3, 8'd128, 8'd200, 8'd128, 8'd3, 8'd3};

        // Reset held with enable active and random inputs.
        en = 1'b1; a = 8'd77; b = 8'd13; c = 8'd250; d = 8'd1;
        #1 check_zero("rst_initial");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("rst_held");
        rst = 1'b0;
        en = 1'b0;

        // Table-driven vectors.
        foreach (vecs[i])
            apply(1'b1, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].d,
                  {vecs[i].ea, vecs[i].eb, vecs[i].ec, vecs[i].ed});

        // Enable hold.
        apply(1'b1, 8'd5, 8'd9, 8'd1, 8'd3, {8'd9, 8'd5, 8'd3, 8'd1});
        apply(1'b0, 8'd100, 8'd200, 8'd50, 8'd25, 32'd0);
        apply(1'b0, 8'd1, 8'd2, 8'd3, 8'd4, 32'd0);
        apply(1'b1, 8'd100, 8'd200, 8'd50, 8'd25, {8'd200, 8'd100, 8'd50, 8'd25});

        // Asynchronous reset mid-cycle, then recovery.
        #2 rst = 1'b1;
        #1 check_zero("rst_async");
        @(posedge clk);
        @(negedge clk);
        check_zero("rst_async_held");
        rst = 1'b0;
        q.delete();
        last_exp = '0;
        apply(1'b0, 8'd9, 8'd8, 8'd7, 8'd6, 32'd0);
        apply(1'b1, 8'd1, 8'd4, 8'd2, 8'd3, {8'd4, 8'd3, 8'd2, 8'd1});

        // Back-to-back alternation.
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0)
                apply(1'b1, 8'd11, 8'd99, 8'd55, 8'd33, {8'd99, 8'd55, 8'd33, 8'd11});
            else
                apply(1'b1, 8'd250, 8'd2, 8'd128, 8'd127, {8'd250, 8'd128, 8'd127, 8'd2});
        end

        // Random regression.
        for (int k = 0; k < 1000; k++) begin
            r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
            apply(1'b1, r0, r1, r2, r3, sort4(r0, r1, r2, r3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
